// File: rtl/contador_seq_ctrl_if.sv
// Command/status bundle between the control logic and contador_seq_ctrl.
// PRESCALE_EN adds the presc_div field and the PRESC_W parameter.
interface contador_seq_ctrl_if #(
  parameter int unsigned WIDTH = 4
`ifdef PRESCALE_EN
  , parameter int unsigned PRESC_W = 4
`endif
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] limit;
`ifdef PRESCALE_EN
  logic [PRESC_W-1:0] presc_div;
`endif
  logic [WIDTH-1:0] count;
  logic [1:0]       state;
  logic             busy;
  logic             done;

`ifdef PRESCALE_EN
  modport master (output start, stop, pause, auto_reload, limit, presc_div,
                  input  count, state, busy, done);
  modport slave  (input  start, stop, pause, auto_reload, limit, presc_div,
                  output count, state, busy, done);
`else
  modport master (output start, stop, pause, auto_reload, limit,
                  input  count, state, busy, done);
  modport slave  (input  start, stop, pause, auto_reload, limit,
                  output count, state, busy, done);
`endif
endinterface

// File: rtl/contador_seq_ctrl.sv
// Run/stop/pause sequencer owning a WIDTH-bit up-count register and a 4-state FSM.
// Optional tick prescaler enabled by defining PRESCALE_EN.
module contador_seq_ctrl #(
  parameter int unsigned WIDTH = 4
`ifdef PRESCALE_EN
  , parameter int unsigned PRESC_W = 4
`endif
) (
  input  logic               clk,
  input  logic               rst,
  contador_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] lim_q;
  logic             mode_q;
  logic             busy_q;
  logic             done_q;
  logic             tick_c;
  logic             terminal_c;

`ifdef PRESCALE_EN
  logic [PRESC_W-1:0] presc_q;
  assign tick_c = (state_q == S_RUN) && (presc_q == bus.presc_div);
`else
  assign tick_c = (state_q == S_RUN);
`endif

  assign terminal_c = tick_c && (count_q == lim_q);

  // Sequencer: stop > pause > start, commands not meaningful in a state are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      lim_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PRESCALE_EN
      presc_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.stop && (state_q == S_DONE)) begin
            state_q <= S_IDLE;
            count_q <= '0;
`ifdef PRESCALE_EN
            presc_q <= '0;
`endif
          end else if (bus.start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            count_q <= '0;
            lim_q   <= bus.limit;
            mode_q  <= bus.auto_reload;
`ifdef PRESCALE_EN
            presc_q <= '0;
`endif
          end
        end
        S_RUN: begin
          if (bus.stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            count_q <= '0;
`ifdef PRESCALE_EN
            presc_q <= '0;
`endif
          end else if (bus.pause) begin
            state_q <= S_PAUSE;
          end else begin
`ifdef PRESCALE_EN
            presc_q <= tick_c ? '0 : presc_q + PRESC_W'(1);
`endif
            if (terminal_c) begin
              done_q <= 1'b1;
              if (mode_q) begin
                count_q <= '0;
              end else begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
              end
            end else if (tick_c) begin
              count_q <= count_q + WIDTH'(1);
            end
          end
        end
        S_PAUSE: begin
          // pause is meaningless here, so a concurrent start still resumes
          if (bus.stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            count_q <= '0;
`ifdef PRESCALE_EN
            presc_q <= '0;
`endif
          end else if (bus.start) begin
            state_q <= S_RUN;
          end
        end
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.state = state_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_contador_seq_ctrl.sv
// Self-checking bench for contador_seq_ctrl: directed vector table, corner sequences,
// and randomized commands against a cycle-level reference model.
module tb_contador_seq_ctrl;
  localparam int unsigned WIDTH = 4;
  localparam int          MODN  = 1 << WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef PRESCALE_EN
  contador_seq_ctrl_if #(.WIDTH(WIDTH), .PRESC_W(4)) bus ();
  contador_seq_ctrl #(.WIDTH(WIDTH), .PRESC_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  contador_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();
  contador_seq_ctrl #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: 0=IDLE 1=RUN 2=PAUSE 3=DONE
  int m_state = 0, m_count = 0, m_lim = 0, m_presc = 0, m_div = 0;
  bit m_mode = 0, m_done = 0;

  typedef struct {
    bit st, sp, pa, ar;
    int lim;
    int rep;
    int e_count;
    int e_state;
    bit e_done;
  } vec_t;
  vec_t tbl[14];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit st, sp, pa, ar, input int lim, input bit r);
    bit tick;
    if (r) begin
      m_state = 0; m_count = 0; m_lim = 0; m_mode = 0; m_done = 0; m_presc = 0;
      return;
    end
    m_done = 0;
    if (sp && m_state != 0) begin
      m_state = 0; m_count = 0; m_presc = 0;
    end else if (m_state == 0 || m_state == 3) begin
      if (st) begin
        m_state = 1; m_count = 0; m_lim = lim; m_mode = ar; m_presc = 0;
      end
    end else if (m_state == 2) begin
      if (st) m_state = 1;
    end else if (pa) begin
      m_state = 2;
    end else begin
      tick = (m_presc == m_div);
      m_presc = tick ? 0 : m_presc + 1;
      if (tick) begin
        if (m_count == m_lim) begin
          m_done = 1;
          if (m_mode) m_count = 0;
          else m_state = 3;
        end else begin
          m_count = (m_count + 1) % MODN;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the clock, compare against the model
  task automatic apply(input bit st, sp, pa, ar, input int lim, input bit r);
    bus.start = st; bus.stop = sp; bus.pause = pa; bus.auto_reload = ar;
    bus.limit = WIDTH'(lim); rst = r;
    @(posedge clk); #1;
    model_step(st, sp, pa, ar, lim, r);
    check("model_count", int'(bus.count), m_count);
    check("model_state", int'(bus.state), m_state);
    check("model_busy",  int'(bus.busy), int'(m_state == 1 || m_state == 2));
    check("model_done",  int'(bus.done), int'(m_done));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit st, sp, pa, ar, r;
    int lim;

    bus.start = 0; bus.stop = 0; bus.pause = 0; bus.auto_reload = 0; bus.limit = '0;
`ifdef PRESCALE_EN
    bus.presc_div = '0;
`endif
    rst = 1;

    apply(0, 0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 1);
    check("reset_state", int'(bus.state), 0);
    check("reset_count", int'(bus.count), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);

    // st sp pa ar lim rep -> count state done
    tbl[0]  = '{1, 0, 0, 0, 3, 1,  0, 1, 0};
    tbl[1]  = '{0, 0, 0, 1, 7, 1,  1, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 1,  2, 1, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 1,  3, 1, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 1,  3, 3, 1};
    tbl[5]  = '{0, 0, 0, 0, 0, 10, 3, 3, 0};
    tbl[6]  = '{0, 1, 0, 0, 0, 1,  0, 0, 0};
    tbl[7]  = '{0, 1, 1, 0, 0, 1,  0, 0, 0};
    tbl[8]  = '{1, 0, 0, 1, 0, 1,  0, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 5, 3,  0, 1, 1};
    tbl[10] = '{0, 0, 1, 0, 0, 1,  0, 2, 0};
    tbl[11] = '{1, 0, 0, 0, 0, 1,  0, 1, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 1,  0, 1, 1};
    tbl[13] = '{0, 1, 0, 0, 0, 1,  0, 0, 0};
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < tbl[i].rep; k++) begin
        apply(tbl[i].st, tbl[i].sp, tbl[i].pa, tbl[i].ar, tbl[i].lim, 0);
        check($sformatf("vec%0d_count", i), int'(bus.count), tbl[i].e_count);
        check($sformatf("vec%0d_state", i), int'(bus.state), tbl[i].e_state);
        check($sformatf("vec%0d_done", i), int'(bus.done), int'(tbl[i].e_done));
        check($sformatf("vec%0d_busy", i), int'(bus.busy),
              int'(tbl[i].e_state == 1 || tbl[i].e_state == 2));
      end
    end

    // Reset held two cycles mid-run
    apply(1, 0, 0, 0, 9, 0);
    idle(5);
    check("t1_count5", int'(bus.count), 5);
    apply(0, 0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 1);
    check("t1_state", int'(bus.state), 0);
    check("t1_count", int'(bus.count), 0);
    check("t1_done", int'(bus.done), 0);
    check("t1_busy", int'(bus.busy), 0);

    // Auto-reload with limit 2
    apply(1, 0, 0, 1, 2, 0);
    for (int i = 1; i <= 9; i++) begin
      apply(0, 0, 0, 0, 0, 0);
      check("t3_count", int'(bus.count), i % 3);
      check("t3_done", int'(bus.done), int'(i % 3 == 0));
    end
    apply(0, 1, 0, 0, 0, 0);

    // Pause at count 4 for 5 cycles, then resume to terminal 9
    apply(1, 0, 0, 0, 9, 0);
    idle(4);
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 1, 0, 0, 0);
      check("t4_paused_count", int'(bus.count), 4);
      check("t4_paused_state", int'(bus.state), 2);
      check("t4_paused_done", int'(bus.done), 0);
    end
    apply(1, 0, 0, 0, 0, 0);
    check("t4_resume_count", int'(bus.count), 4);
    check("t4_resume_state", int'(bus.state), 1);
    for (int k = 5; k <= 9; k++) begin
      apply(0, 0, 0, 0, 0, 0);
      check("t4_count", int'(bus.count), k);
      check("t4_done_early", int'(bus.done), 0);
    end
    apply(0, 0, 0, 0, 0, 0);
    check("t4_done", int'(bus.done), 1);
    check("t4_state", int'(bus.state), 3);
    check("t4_hold", int'(bus.count), 9);

    // DONE -> start re-latches; then all commands together in RUN
    apply(1, 0, 0, 1, 15, 0);
    check("t5_relatch_count", int'(bus.count), 0);
    idle(6);
    check("t5_count6", int'(bus.count), 6);
    apply(1, 1, 1, 0, 0, 0);
    check("t5_stop_state", int'(bus.state), 0);
    check("t5_stop_count", int'(bus.count), 0);
    check("t5_stop_done", int'(bus.done), 0);
    apply(1, 0, 0, 1, 15, 0);
    idle(15);
    check("t5_count15", int'(bus.count), 15);
    apply(0, 0, 0, 0, 0, 0);
    check("t5_wrap_count", int'(bus.count), 0);
    check("t5_wrap_done", int'(bus.done), 1);
    check("t5_wrap_state", int'(bus.state), 1);
    apply(0, 1, 0, 0, 0, 0);

`ifdef PRESCALE_EN
    bus.presc_div = 4'd2; m_div = 2;
    apply(1, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 6; i++) begin
      apply(0, 0, 0, 0, 0, 0);
      check("t6_count", int'(bus.count), (i >= 3) ? 1 : 0);
      check("t6_done", int'(bus.done), int'(i == 6));
    end
    check("t6_state", int'(bus.state), 3);
    apply(0, 1, 0, 0, 0, 0);
    m_div = int'($urandom_range(0, 3));
    bus.presc_div = 4'(m_div);
`endif

    // Randomized commands against the model
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) < 2);
      st = ($urandom_range(0, 99) < 30);
      sp = ($urandom_range(0, 99) < 6);
      pa = ($urandom_range(0, 99) < 10);
      ar = 1'($urandom_range(0, 1));
      lim = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4));
      apply(st, sp, pa, ar, lim, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
